// File: rtl/pp_seq_accumulator_if.sv
// Handshake bundle between the partial-product generator, the sequential accumulator
// and the multiplier result register.
interface pp_seq_accumulator_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned PPW  = 2 * N - 1;
  localparam int unsigned OUTW = 2 * N;

  logic [N*PPW-1:0] pp_flat;
  logic             in_valid;
  logic             in_ready;
  logic [OUTW-1:0]  product;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  // Producer side: offers partial-product sets and consumes the product.
  modport master (
    output pp_flat, in_valid, out_ready,
    input  in_ready, product, out_valid, busy
  );

  // Accumulator side.
  modport slave (
    input  pp_flat, in_valid, out_ready,
    output in_ready, product, out_valid, busy
  );
endinterface

// File: rtl/pp_seq_accumulator.sv
// Sequential reduction of N partial products into a 2N-bit product under valid/ready.
// Optional macro PP_ACC_DUAL_EN adds two partial products per cycle (N must be even).
module pp_seq_accumulator #(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pp_seq_accumulator_if.slave  bus
);
  localparam int unsigned PPW  = 2 * N - 1;
  localparam int unsigned OUTW = 2 * N;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;

  if (N < 2) begin : g_bad_n
    $error("pp_seq_accumulator: N must be >= 2");
  end

`ifdef PP_ACC_DUAL_EN
  if ((N % 2) != 0) begin : g_odd_n
    $error("pp_seq_accumulator: PP_ACC_DUAL_EN requires even N");
  end
  localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);
`else
  localparam logic [CW-1:0] LAST = CW'(N - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OUTW-1:0]     acc_q, acc_d;
  logic [OUTW-1:0]     product_q, product_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic [PPW-1:0]      pp_q [N];
  logic [PPW-1:0]      pp_d [N];
  logic [OUTW-1:0]     sum_c;

  // Adder: one or two zero-extended slices per cycle.
`ifdef PP_ACC_DUAL_EN
  logic [CW-1:0] lo_idx_c, hi_idx_c;
  assign lo_idx_c = CW'({cnt_q, 1'b0});
  assign hi_idx_c = CW'({cnt_q, 1'b1});
  assign sum_c    = acc_q + OUTW'(pp_q[lo_idx_c]) + OUTW'(pp_q[hi_idx_c]);
`else
  assign sum_c    = acc_q + OUTW'(pp_q[cnt_q]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int unsigned k = 0; k < N; k++) pp_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      for (int unsigned k = 0; k < N; k++) pp_q[k] <= pp_d[k];
    end
  end

  // Next state; outputs are computed for the next cycle so they leave as flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    for (int unsigned k = 0; k < N; k++) pp_d[k] = pp_q[k];

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          for (int unsigned k = 0; k < N; k++) pp_d[k] = bus.pp_flat[k*PPW +: PPW];
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = S_ACCUM;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_ACCUM: begin
        acc_d = sum_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          product_d   = sum_c;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.product   = product_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
endmodule
